// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: register word addresses and bus FSM states.
// Also used by the CPU bus decoder and the testbench.
package gpio_ctrl_pkg;

  localparam int GPIO_WIDTH  = 16;
  localparam int GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_DR  = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_TS  = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IN  = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IE  = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IS  = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_EP  = 3'd5;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_SET = 3'd6;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_CLR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for the raw pad inputs plus a history flop and a
// per-pin polarity-selected edge detector (polarity bit 0 = rising, 1 = falling).
module gpio_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  input  logic [WIDTH-1:0] polarity,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] edge_ev
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] prev_r;

  // Synchronizer chain and previous-level history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      prev_r  <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= pins;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign level   = sync2_r;
  assign edge_ev = (polarity & prev_r & ~sync2_r) | (~polarity & ~prev_r & sync2_r);

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: register file, req/ack bus FSM, pad data and
// drive-enable outputs, and edge-event interrupt status with a registered irq.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH  = GPIO_WIDTH,
  parameter int ADDR_W = GPIO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [WIDTH-1:0]  bus_wdata,
  output logic [WIDTH-1:0]  bus_rdata,
  output logic              bus_ack,
  input  logic [WIDTH-1:0]  gpio_input,
  output logic [WIDTH-1:0]  gpio_dr,
  output logic [WIDTH-1:0]  gpio_ts,
  output logic              irq
);

  bus_state_e       state_r;
  bus_state_e       state_next_s;
  logic             access_s;
  logic             wr_s;
  logic             rd_s;
  logic             ack_r;
  logic             irq_r;
  logic [WIDTH-1:0] dr_r;
  logic [WIDTH-1:0] ts_r;
  logic [WIDTH-1:0] ie_r;
  logic [WIDTH-1:0] is_r;
  logic [WIDTH-1:0] ep_r;
  logic [WIDTH-1:0] rdata_r;
  logic [WIDTH-1:0] dr_next_s;
  logic [WIDTH-1:0] ts_next_s;
  logic [WIDTH-1:0] ie_next_s;
  logic [WIDTH-1:0] ep_next_s;
  logic [WIDTH-1:0] is_next_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] rd_mux_s;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] ev_s;

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .pins     (gpio_input),
    .polarity (ep_r),
    .level    (sync_s),
    .edge_ev  (ev_s)
  );

  // Only IDLE accepts a request, so a held bus_req performs exactly one access.
  assign access_s = (state_r == ST_IDLE) && bus_req;
  assign wr_s     = access_s && bus_we;
  assign rd_s     = access_s && !bus_we;

  // Bus FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus_req) state_next_s = ST_ACK;
        else         state_next_s = ST_IDLE;
      end
      ST_ACK:  state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (!bus_req) state_next_s = ST_IDLE;
        else          state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Register write decode; IN writes fall through and are ignored
  always_comb begin
    dr_next_s = dr_r;
    ts_next_s = ts_r;
    ie_next_s = ie_r;
    ep_next_s = ep_r;
    w1c_s     = {WIDTH{1'b0}};
    if (wr_s) begin
      case (bus_addr)
        GPIO_DR:  dr_next_s = bus_wdata;
        GPIO_TS:  ts_next_s = bus_wdata;
        GPIO_IE:  ie_next_s = bus_wdata;
        GPIO_IS:  w1c_s     = bus_wdata;
        GPIO_EP:  ep_next_s = bus_wdata;
        GPIO_SET: dr_next_s = dr_r | bus_wdata;
        GPIO_CLR: dr_next_s = dr_r & ~bus_wdata;
        default:  dr_next_s = dr_r;
      endcase
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end
  end

  // A same-cycle edge event outranks the W1C clear so no event is lost.
  assign is_next_s = (is_r & ~w1c_s) | ev_s;

  // Read data mux; write-only strobes read back as zero
  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    case (bus_addr)
      GPIO_DR:  rd_mux_s = dr_r;
      GPIO_TS:  rd_mux_s = ts_r;
      GPIO_IN:  rd_mux_s = sync_s;
      GPIO_IE:  rd_mux_s = ie_r;
      GPIO_IS:  rd_mux_s = is_r;
      GPIO_EP:  rd_mux_s = ep_r;
      default:  rd_mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Register file, read latch, ack pulse and interrupt output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_r    <= {WIDTH{1'b0}};
      ts_r    <= {WIDTH{1'b0}};
      ie_r    <= {WIDTH{1'b0}};
      is_r    <= {WIDTH{1'b0}};
      ep_r    <= {WIDTH{1'b0}};
      rdata_r <= {WIDTH{1'b0}};
      ack_r   <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      dr_r  <= dr_next_s;
      ts_r  <= ts_next_s;
      ie_r  <= ie_next_s;
      is_r  <= is_next_s;
      ep_r  <= ep_next_s;
      ack_r <= access_s;
      irq_r <= |(is_next_s & ie_next_s);
      if (rd_s) begin
        rdata_r <= rd_mux_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign bus_rdata = rdata_r;
  assign bus_ack   = ack_r;
  assign gpio_dr   = dr_r;
  assign gpio_ts   = ts_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: reset, output path, input sync, edge irq,
// W1C race and bus handshake, with hand-computed expected values.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        bus_req;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic [15:0] gpio_input;
  logic [15:0] gpio_dr;
  logic [15:0] gpio_ts;
  logic        irq;

  int vectors;
  int miscompares;

  gpio_ctrl #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .gpio_input (gpio_input),
    .gpio_dr    (gpio_dr),
    .gpio_ts    (gpio_ts),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One bus access: request, wait (bounded) for ack, drop request, let FSM return to IDLE.
  task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd);
    logic got;
    got = 1'b0;
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus_ack) begin
        got = 1'b1;
        break;
      end
    end
    rd = bus_rdata;
    bus_req = 1'b0;
    check("ack_seen", {15'd0, got}, 16'd1);
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] rd;
  int acks;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 3'd0;
    bus_wdata = 16'h0000; gpio_input = 16'h0000;
    wait_cycles(3);
    check("rst_dr",    gpio_dr, 16'h0000);
    check("rst_ts",    gpio_ts, 16'h0000);
    check("rst_ack",   {15'd0, bus_ack}, 16'd0);
    check("rst_rdata", bus_rdata, 16'h0000);
    check("rst_irq",   {15'd0, irq}, 16'd0);

    // Reset asserted during a pending write: no ack, no update
    rst = 1'b0;
    wait_cycles(1);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = GPIO_TS; bus_wdata = 16'hFFFF;
    #2 rst = 1'b1;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus_ack) acks++;
    end
    check("rst_mid_no_ack", 16'(acks), 16'd0);
    bus_req = 1'b0;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(1);
    check("rst_rel_ts", gpio_ts, 16'h0000);
    check("rst_rel_dr", gpio_dr, 16'h0000);

    // Output path
    bus_xfer(1'b1, GPIO_DR, 16'hA5A5, rd);
    bus_xfer(1'b1, GPIO_TS, 16'h00FF, rd);
    check("pad_dr", gpio_dr, 16'hA5A5);
    check("pad_ts", gpio_ts, 16'h00FF);
    bus_xfer(1'b0, GPIO_DR, 16'h0000, rd);
    check("rd_dr", rd, 16'hA5A5);
    bus_xfer(1'b0, GPIO_TS, 16'h0000, rd);
    check("rd_ts", rd, 16'h00FF);
    bus_xfer(1'b1, GPIO_SET, 16'h0002, rd);
    check("set_dr", gpio_dr, 16'hA5A7);
    bus_xfer(1'b1, GPIO_CLR, 16'h0005, rd);
    check("clr_dr", gpio_dr, 16'hA5A2);
    bus_xfer(1'b0, GPIO_SET, 16'h0000, rd);
    check("rd_set_zero", rd, 16'h0000);

    // Input path: 2-cycle synchronizer latency
    gpio_input = 16'h1234;
    wait_cycles(2);
    bus_xfer(1'b0, GPIO_IN, 16'h0000, rd);
    check("rd_in", rd, 16'h1234);
    gpio_input = 16'h5678;
    bus_xfer(1'b0, GPIO_IN, 16'h0000, rd);
    check("rd_in_late", rd, 16'h1234);
    bus_xfer(1'b1, GPIO_IN, 16'hFFFF, rd);
    bus_xfer(1'b0, GPIO_IN, 16'h0000, rd);
    check("in_ro", rd, 16'h5678);
    gpio_input = 16'h0000;
    wait_cycles(4);

    // Edge interrupts
    bus_xfer(1'b1, GPIO_IS, 16'hFFFF, rd);
    bus_xfer(1'b1, GPIO_EP, 16'h0000, rd);
    bus_xfer(1'b1, GPIO_IE, 16'h0001, rd);
    check("irq_idle", {15'd0, irq}, 16'd0);
    bus_xfer(1'b0, GPIO_IS, 16'h0000, rd);
    check("is_cleared", rd, 16'h0000);
    gpio_input = 16'h0001;
    wait_cycles(4);
    check("irq_pin0", {15'd0, irq}, 16'd1);
    bus_xfer(1'b0, GPIO_IS, 16'h0000, rd);
    check("is_pin0", rd, 16'h0001);
    gpio_input = 16'h0003;
    wait_cycles(4);
    bus_xfer(1'b0, GPIO_IS, 16'h0000, rd);
    check("is_pin1", rd, 16'h0003);
    check("irq_pin1", {15'd0, irq}, 16'd1);
    gpio_input = 16'h0002;
    wait_cycles(4);
    bus_xfer(1'b0, GPIO_IS, 16'h0000, rd);
    check("is_fall_ignored", rd, 16'h0003);

    // W1C on IS[0] lands on the same edge as a new pin-0 rising event
    gpio_input = 16'h0003;
    wait_cycles(1);
    wait_cycles(1);
    bus_xfer(1'b1, GPIO_IS, 16'h0001, rd);
    bus_xfer(1'b0, GPIO_IS, 16'h0000, rd);
    check("w1c_race_is", rd, 16'h0003);
    check("w1c_race_irq", {15'd0, irq}, 16'd1);
    bus_xfer(1'b1, GPIO_IS, 16'h0001, rd);
    bus_xfer(1'b0, GPIO_IS, 16'h0000, rd);
    check("w1c_is", rd, 16'h0002);
    check("w1c_irq", {15'd0, irq}, 16'd0);

    // Held request: one ack, one update
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = GPIO_SET; bus_wdata = 16'h0001;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus_ack) acks++;
    end
    bus_req = 1'b0;
    wait_cycles(2);
    check("hold_one_ack", 16'(acks), 16'd1);
    check("hold_dr", gpio_dr, 16'hA5A3);
    bus_xfer(1'b1, GPIO_CLR, 16'h0001, rd);
    check("hold_clr_dr", gpio_dr, 16'hA5A2);

    // Back-to-back accesses
    bus_xfer(1'b1, GPIO_IE, 16'h00F0, rd);
    bus_xfer(1'b1, GPIO_EP, 16'h00FF, rd);
    bus_xfer(1'b0, GPIO_IE, 16'h0000, rd);
    check("b2b_ie", rd, 16'h00F0);
    bus_xfer(1'b0, GPIO_EP, 16'h0000, rd);
    check("b2b_ep", rd, 16'h00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
